// File: rtl/dma_write_framer_if.sv
// Signal bundle between the result-stream core, the framer and the conv write-DMA.
// The framer sits on the slave modport; the core/DMA side uses master.
interface dma_write_framer_if #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = 32,
    parameter int LEN_W  = 32
);
    logic              start;
    logic [31:0]       cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [63:0]       dma_cmd;
    logic              dma_cmd_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic              dma_wr_introut;
    logic              busy;
    logic              done;

    modport master (
        output start, cmd_addr, cmd_len, s_data, s_valid, m_tready, dma_wr_introut,
        input  dma_cmd, dma_cmd_valid, s_ready, m_tdata, m_tkeep, m_tlast, m_tvalid, busy, done
    );

    modport slave (
        input  start, cmd_addr, cmd_len, s_data, s_valid, m_tready, dma_wr_introut,
        output dma_cmd, dma_cmd_valid, s_ready, m_tdata, m_tkeep, m_tlast, m_tvalid, busy, done
    );
endinterface

// File: rtl/dma_write_framer.sv
// Issues one {addr,len} DMA write command and frames the core's result stream
// into exactly ceil(len/32) beats with tkeep/tlast; done after tlast and DMA irq.
module dma_write_framer #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = 32,
    parameter int LEN_W  = 32
) (
    input logic               clk,
    input logic               rst,
    dma_write_framer_if.slave bus
);
    localparam int KB = $clog2(KEEP_W);
    localparam logic [LEN_W:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, CMD, STREAM, WAIT_INT} state_t;
    state_t state;

    logic [31:0]       addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W:0]    beats_q, acc_cnt, beats_in;
    logic [DATA_W-1:0] sk_data;
    logic [KEEP_W-1:0] sk_keep, keep_in;
    logic              sk_last, sk_vld, int_seen;
    logic              acc, pop, last_in;
    logic [KB-1:0]     rem;

    // One extra bit so a length near 2^LEN_W cannot wrap the beat count.
    assign beats_in = ({1'b0, bus.cmd_len} + (LEN_W+1)'(KEEP_W - 1)) >> KB;
    assign rem      = len_q[KB-1:0];

    // Skid buffer = output register (head) + one spare entry; full when both hold data.
    assign bus.s_ready = (state == STREAM) && !(bus.m_tvalid && sk_vld) && (acc_cnt < beats_q);
    assign acc     = bus.s_valid && bus.s_ready;
    assign pop     = bus.m_tvalid && bus.m_tready;
    assign last_in = (acc_cnt + ONE == beats_q);
    assign keep_in = (last_in && rem != '0) ? ~({KEEP_W{1'b1}} << rem) : {KEEP_W{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            addr_q            <= '0;
            len_q             <= '0;
            beats_q           <= '0;
            acc_cnt           <= '0;
            int_seen          <= 1'b0;
            sk_data           <= '0;
            sk_keep           <= '0;
            sk_last           <= 1'b0;
            sk_vld            <= 1'b0;
            bus.dma_cmd       <= '0;
            bus.dma_cmd_valid <= 1'b0;
            bus.m_tdata       <= '0;
            bus.m_tkeep       <= '0;
            bus.m_tlast       <= 1'b0;
            bus.m_tvalid      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
        end else begin
            bus.done          <= 1'b0;
            bus.dma_cmd_valid <= 1'b0;

            case (state)
                IDLE: if (bus.start) begin
                    if (bus.cmd_len != '0) begin
                        addr_q   <= bus.cmd_addr;
                        len_q    <= bus.cmd_len;
                        beats_q  <= beats_in;
                        acc_cnt  <= '0;
                        int_seen <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= CMD;
                    end else begin
                        bus.done <= 1'b1;
                    end
                end
                CMD: begin
                    bus.dma_cmd_valid <= 1'b1;
                    bus.dma_cmd       <= {addr_q, 32'(len_q)};
                    if (bus.dma_wr_introut) int_seen <= 1'b1;
                    state <= STREAM;
                end
                STREAM: begin
                    if (pop && bus.m_tlast) begin
                        // An irq that already arrived lets us finish straight from the tlast handshake.
                        if (int_seen || bus.dma_wr_introut) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            int_seen <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= WAIT_INT;
                        end
                    end else if (bus.dma_wr_introut) begin
                        int_seen <= 1'b1;
                    end
                end
                WAIT_INT: if (bus.dma_wr_introut) begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (acc) acc_cnt <= acc_cnt + ONE;

            // A pop with the spare full cannot coincide with an accept: s_ready is low then.
            if (pop) begin
                if (sk_vld) begin
                    bus.m_tdata <= sk_data;
                    bus.m_tkeep <= sk_keep;
                    bus.m_tlast <= sk_last;
                    sk_vld      <= 1'b0;
                end else if (acc) begin
                    bus.m_tdata <= bus.s_data;
                    bus.m_tkeep <= keep_in;
                    bus.m_tlast <= last_in;
                end else begin
                    bus.m_tvalid <= 1'b0;
                end
            end else if (acc) begin
                if (!bus.m_tvalid) begin
                    bus.m_tdata  <= bus.s_data;
                    bus.m_tkeep  <= keep_in;
                    bus.m_tlast  <= last_in;
                    bus.m_tvalid <= 1'b1;
                end else begin
                    sk_data <= bus.s_data;
                    sk_keep <= keep_in;
                    sk_last <= last_in;
                    sk_vld  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dma_write_framer.sv
// Bench for dma_write_framer: table vectors, random transfers against a beat-level
// model, and reset-in-flight sequences.
module tb_dma_write_framer;
    localparam int DATA_W = 256;
    localparam int KEEP_W = 32;
    localparam int LEN_W  = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dma_write_framer_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W)) bus ();

    dma_write_framer #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        int          rdy_pct;
        int          vld_pct;
        int          int_mode;   // 0: irq after tlast, 1: irq early in the stream
        bit          xstart;     // extra start while busy
        int          exp_nb;
        logic [31:0] exp_lkeep;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit coin(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.s_data = '0;
        bus.s_valid = 1'b0; bus.m_tready = 1'b0; bus.dma_wr_introut = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        logic [255:0] v;
        v = 256'({bus.dma_cmd, bus.m_tkeep, bus.dma_cmd_valid, bus.s_ready, bus.m_tvalid,
                  bus.m_tlast, bus.busy, bus.done, |bus.m_tdata});
        chk_w(nm, v, '0);
    endtask

    // One complete transfer, iteration 0 drives start. Called #1 after a posedge.
    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic [31:0] len,
                            input int rdy_pct, input int vld_pct, input int int_mode,
                            input bit xstart, input int exp_nb, input logic [31:0] exp_lkeep);
        logic [255:0] din[$];
        logic [255:0] pdata = '0;
        logic [31:0]  pkeep = '0;
        logic         plast = 1'b0;
        bit           stall = 1'b0;
        int acc = 0, nout = 0, cmd_cnt = 0, done_cnt = 0, misc_bad = 0;
        int done_it = -1, tl_it = -1, int_it = -1, first_hs = -1, last_hs = -1, exp_done;
        int budget = 40 * exp_nb + 60;
        for (int i = 0; i < exp_nb + 4; i++) din.push_back(rand256());
        for (int it = 0; it < budget; it++) begin
            if (it > 0) begin
                if (bus.dma_cmd_valid) begin
                    cmd_cnt++;
                    chk({tag, " cmd_time"}, longint'(it), 2);
                    chk({tag, " cmd_val"}, longint'(bus.dma_cmd), longint'({addr, len}));
                end
                if (bus.done) begin
                    done_cnt++;
                    done_it = it;
                end
                if (stall) begin
                    chk({tag, " hold"}, longint'({bus.m_tvalid, bus.m_tlast, bus.m_tkeep}),
                        longint'({1'b1, plast, pkeep}));
                    chk_w({tag, " hold_data"}, bus.m_tdata, pdata);
                end
            end
            if (bus.busy !== ((len != 0) && it >= 1 && done_it < 0)) misc_bad++;
            if (it < 2 && bus.s_ready) misc_bad++;
            if (done_it >= 0) break;

            bus.start    = (it == 0) || (xstart && it == 4);
            bus.cmd_addr = (it == 0) ? addr : ~addr;
            bus.cmd_len  = (it == 0) ? len : 32'd32;
            bus.m_tready = coin(rdy_pct);
            bus.s_valid  = coin(vld_pct);
            bus.s_data   = (acc < din.size()) ? din[acc] : '0;
            bus.dma_wr_introut = (len != 0) && ((int_mode == 1 && it == 2) ||
                                 (int_mode == 0 && tl_it >= 0 && it == tl_it + 2));
            if (bus.dma_wr_introut) int_it = it;

            if (bus.m_tvalid && bus.m_tready) begin
                if (nout < exp_nb) begin
                    chk_w({tag, " data"}, bus.m_tdata, din[nout]);
                    chk({tag, " tlast"}, longint'(bus.m_tlast), longint'(nout == exp_nb - 1));
                    chk({tag, " tkeep"}, longint'(bus.m_tkeep),
                        longint'((nout == exp_nb - 1) ? exp_lkeep : 32'hFFFF_FFFF));
                end else begin
                    chk({tag, " extra_beat"}, longint'(nout + 1), longint'(exp_nb));
                end
                if (first_hs < 0) first_hs = it;
                last_hs = it;
                if (bus.m_tlast) tl_it = it;
                nout++;
            end
            if (bus.s_valid && bus.s_ready) acc++;
            stall = bus.m_tvalid && !bus.m_tready;
            pdata = bus.m_tdata;
            pkeep = bus.m_tkeep;
            plast = bus.m_tlast;
            @(posedge clk);
            #1;
        end
        exp_done = (len == 0) ? 1 : (((int_it > tl_it) ? int_it : tl_it) + 1);
        chk({tag, " done_time"}, longint'(done_it), longint'(exp_done));
        chk({tag, " done_cnt"}, longint'(done_cnt), 1);
        chk({tag, " cmd_cnt"}, longint'(cmd_cnt), longint'(len != 0));
        chk({tag, " beats_out"}, longint'(nout), longint'(exp_nb));
        chk({tag, " beats_in"}, longint'(acc), longint'(exp_nb));
        chk({tag, " busy_sready"}, longint'(misc_bad), 0);
        if (rdy_pct == 100 && vld_pct == 100 && exp_nb > 0) begin
            chk({tag, " first_beat"}, longint'(first_hs), 3);
            chk({tag, " back_to_back"}, longint'(last_hs - first_hs), longint'(exp_nb - 1));
        end
    endtask

    // Start a long transfer, let nhs beats through, then reset in flight.
    task automatic rst_mid(input string tag, input logic [31:0] len, input int nhs);
        int nout = 0;
        for (int it = 0; it < 60 && nout < nhs; it++) begin
            bus.start = (it == 0); bus.cmd_addr = 32'hA000_0000; bus.cmd_len = len;
            bus.s_valid = 1'b1; bus.s_data = rand256(); bus.m_tready = 1'b1;
            bus.dma_wr_introut = 1'b0;
            if (bus.m_tvalid && bus.m_tready) begin
                chk({tag, " mid_beat"}, longint'({bus.m_tlast, bus.m_tkeep}),
                    longint'({1'b0, 32'hFFFF_FFFF}));
                nout++;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, " beats_before_rst"}, longint'(nout), longint'(nhs));
        chk({tag, " busy_before_rst"}, longint'(bus.busy), 1);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_all_zero({tag, " rst_now"});
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero({tag, " rst_hold"});
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero({tag, " after_rst"});
    endtask

    initial begin
        logic [31:0] rlen, rkeep;
        int          rnb;
        rst = 1'b0;
        idle_inputs();
        vecs[0] = '{32'h1000_0000, 32'd128, 100, 100, 0, 1'b0, 4, 32'hFFFF_FFFF};
        vecs[1] = '{32'h2000_0040, 32'd100, 100, 100, 0, 1'b0, 4, 32'h0000_000F};
        vecs[2] = '{32'h3000_0000, 32'd64,   50, 100, 0, 1'b0, 2, 32'hFFFF_FFFF};
        vecs[3] = '{32'h0000_0000, 32'd0,   100, 100, 0, 1'b0, 0, 32'h0000_0000};
        vecs[4] = '{32'h4000_0000, 32'd96,  100, 100, 1, 1'b1, 3, 32'hFFFF_FFFF};
        vecs[5] = '{32'h5000_0000, 32'd33,   70,  60, 1, 1'b0, 2, 32'h0000_0001};
        vecs[6] = '{32'h6000_0020, 32'd31,  100, 100, 0, 1'b0, 1, 32'h7FFF_FFFF};

        #2 rst = 1'b1;
        #1 chk_all_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk_all_zero("idle_after_reset");

        foreach (vecs[i])
            run_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].rdy_pct,
                     vecs[i].vld_pct, vecs[i].int_mode, vecs[i].xstart, vecs[i].exp_nb,
                     vecs[i].exp_lkeep);

        rst_mid("rst8", 32'd256, 2);
        run_xfer("post_rst", 32'h7000_0000, 32'd32, 100, 100, 0, 1'b0, 1, 32'hFFFF_FFFF);
        rst_mid("rst_maxlen", 32'hFFFF_FFFF, 3);

        for (int n = 0; n < 8; n++) begin
            rlen  = (n % 3 == 0) ? $urandom_range(32, 1) : $urandom_range(400, 1);
            rnb   = int'((longint'(rlen) + 31) / 32);
            rkeep = (rlen % 32 == 0) ? 32'hFFFF_FFFF : 32'((64'd1 << (rlen % 32)) - 1);
            run_xfer($sformatf("rnd%0d", n), $urandom, rlen, int'($urandom_range(100, 30)),
                     int'($urandom_range(100, 40)), int'($urandom_range(1, 0)), 1'b0, rnb, rkeep);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_write_framer.md
Name: dma_write_framer

Overview:
- Sits between the accelerator core's output stream and the conv write-DMA channel.
- Latches a write command {address, byte length} on a start pulse and issues one 64-bit command to the DMA.
- Frames the core's unframed 256-bit result stream into exactly the commanded number of beats, generating tkeep and tlast.
- Reports completion only after the last beat is accepted and the DMA write-complete interrupt has arrived.

Parameters:
- DATA_W, 256, stream data width in bits
- KEEP_W, 32, tkeep width (DATA_W/8)
- LEN_W, 32, width of the byte-length field

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; latches cmd_addr/cmd_len
- cmd_addr  in  32  DDR destination byte address
- cmd_len  in  LEN_W  transfer length in bytes
- dma_cmd  out  64  {addr, len} presented to the write-DMA
- dma_cmd_valid  out  1  one-cycle command strobe
- s_data  in  DATA_W  core result data
- s_valid  in  1  core data valid
- s_ready  out  1  framer can accept a beat
- m_tdata  out  DATA_W  AXI-stream data to the DMA
- m_tkeep  out  KEEP_W  byte enables
- m_tlast  out  1  final beat of the transfer
- m_tvalid  out  1  output valid
- m_tready  in  1  DMA ready
- dma_wr_introut  in  1  DMA write-complete pulse
- busy  out  1  high from start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0. State = IDLE, skid buffer empty, counters 0.
- Beat count: beats = ceil(cmd_len/32), computed as (cmd_len+31)>>5 in LEN_W+1 bits so cmd_len=FFFF_FFFF does not wrap. Remainder r = cmd_len[4:0].
- State IDLE:
  - start with cmd_len != 0: latch addr/len/beats, busy=1, go to CMD.
  - start with cmd_len == 0: no command, no beats, done=1 on the next cycle, stay IDLE with busy=0.
- State CMD (1 cycle): dma_cmd_valid=1 with dma_cmd={addr,len}, then go to STREAM. s_ready is 0 in IDLE and CMD.
- State STREAM:
  - Uses a 2-entry skid buffer; s_ready = buffer not full AND accepted-beat count < beats.
  - Sustains full throughput: one beat per cycle when m_tready=1.
  - Each beat is tagged with tkeep and tlast at input acceptance:
    - non-final beat: tkeep = all ones, tlast = 0
    - final beat: tlast = 1; tkeep = all ones if r == 0, else (1<<r)-1 (LSB-first)
  - Once the last beat has been accepted on the input, s_ready = 0; excess upstream beats are stalled, never dropped.
  - AXI rule: once m_tvalid=1, m_tdata/m_tkeep/m_tlast are held stable until m_tready=1.
  - The output handshake on the tlast beat moves the FSM to WAIT_INT.
- State WAIT_INT: wait for dma_wr_introut; then done=1 for one cycle, busy=0, go to IDLE.
- dma_wr_introut arriving before the tlast handshake (in CMD or STREAM) is latched in a sticky flag. The handshake cycle then goes directly to IDLE with done one cycle later.
- start while busy is ignored; the latched command is unaffected.
- Simultaneous events:
  - s_valid and m_tready both high with buffer occupancy 1: accept and emit in the same cycle, occupancy stays 1.
  - done and a new start in the same cycle: the start is accepted (FSM already IDLE).
- Reset mid-transfer: immediate return to IDLE, buffer flushed, all outputs 0, sticky flag cleared. No partial done.
- Latency: dma_cmd_valid asserts 2 cycles after start. First m_tvalid at the earliest 1 cycle after the first s_valid&s_ready (registered output).

Test Plan:
- start, cmd_addr=0x1000_0000, cmd_len=128, s_valid always 1, m_tready always 1 -> dma_cmd=0x10000000_00000080 pulses once; exactly 4 output beats in 4 consecutive cycles; tlast only on beat 4 with tkeep=FFFF_FFFF; s_ready falls after 4 accepts; done 1 cycle after dma_wr_introut.
- cmd_len=100 -> 4 beats; final tkeep=0000_000F (r=4), tlast=1; earlier beats all ones.
- cmd_len=64, random m_tready stalls (~50%) -> data, tkeep and tlast held stable while stalled; order preserved; no beat lost or duplicated.
- cmd_len=0 -> no dma_cmd_valid, no beats, done pulse 1 cycle after start, busy stays 0.
- dma_wr_introut pulsed mid-stream with cmd_len=96 -> sticky flag set; done 1 cycle after the beat-3 handshake; extra start during busy ignored.
- rst asserted after 2 of 8 beats -> all outputs 0 immediately; following start with cmd_len=32 completes normally with a single beat, tlast=1.
